// File: rtl/servo_pwm_multicanal_if.sv
// Control-side bundle of the servo PWM block: run enable, target write port and
// the per-channel PWM/status outputs.
interface servo_pwm_multicanal_if #(
   parameter int N_CANAIS = 4,
   parameter int W_LARG   = 11,
   parameter int W_CANAL  = 2
);
   logic                habilita;
   logic                wr_en;
   logic [W_CANAL-1:0]  wr_canal;
   logic [W_LARG-1:0]   wr_largura;
   logic [N_CANAIS-1:0] pwm;
   logic [N_CANAIS-1:0] movendo;
   logic                fim_periodo;
   logic                wr_erro;

   modport master (
      output habilita, wr_en, wr_canal, wr_largura,
      input  pwm, movendo, fim_periodo, wr_erro
   );

   modport slave (
      input  habilita, wr_en, wr_canal, wr_largura,
      output pwm, movendo, fim_periodo, wr_erro
   );
endinterface

// File: rtl/servo_pwm_multicanal.sv
// Multi-channel servo PWM: one shared period counter, per-channel target/active
// widths, active width stepping toward target at period boundaries.
module servo_pwm_multicanal #(
   parameter int CONF_PERIODO    = 1250,
   parameter int N_CANAIS        = 4,
   parameter int W_LARG          = 11,
   parameter int W_CANAL         = 2,
   parameter int LARGURA_MAX     = 100,
   parameter int LARGURA_INICIAL = 0,
   parameter int PASSO           = 0
) (
   input  logic                    clock_i,
   input  logic                    reset_ni,
   servo_pwm_multicanal_if.slave   bus
);
   localparam logic [W_LARG-1:0]  ULTIMA  = W_LARG'(CONF_PERIODO - 1);
   localparam logic [W_LARG-1:0]  LMAX    = W_LARG'(LARGURA_MAX);
   localparam logic [W_LARG-1:0]  INIC    = W_LARG'(LARGURA_INICIAL);
   localparam logic [W_LARG:0]    PASSO_W = (W_LARG + 1)'(PASSO);
   localparam logic [W_CANAL:0]   N_W     = (W_CANAL + 1)'(N_CANAIS);

   logic [W_LARG-1:0]   contagem_q, contagem_d;
   logic [W_LARG-1:0]   alvo_q  [N_CANAIS];
   logic [W_LARG-1:0]   alvo_d  [N_CANAIS];
   logic [W_LARG-1:0]   atual_q [N_CANAIS];
   logic [W_LARG-1:0]   atual_d [N_CANAIS];
   logic [N_CANAIS-1:0] pwm_q, pwm_d;
   logic                wr_erro_q, wr_erro_d;
   logic                fim;
   logic                wr_ok;
   logic [W_LARG-1:0]   wr_lim;
   logic [W_LARG:0]     dif;
   logic [W_LARG:0]     passo_ef;

   assign fim    = bus.habilita && (contagem_q == ULTIMA);
   assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_canal} < N_W);
   assign wr_lim = (bus.wr_largura > LMAX) ? LMAX : bus.wr_largura;

   always_comb begin
      contagem_d = contagem_q + 1'b1;
      if (!bus.habilita || fim) begin
         contagem_d = '0;
      end
   end

   // The boundary update reads alvo_q, so a write landing on the boundary cycle
   // only takes effect at the following boundary.
   always_comb begin
      dif       = '0;
      passo_ef  = '0;
      wr_erro_d = bus.wr_en && !wr_ok;
      pwm_d     = '0;
      for (int i = 0; i < N_CANAIS; i++) begin
         alvo_d[i]  = alvo_q[i];
         atual_d[i] = atual_q[i];
         pwm_d[i]   = bus.habilita && (contagem_q < atual_q[i]);
         if (fim) begin
            if (PASSO == 0) begin
               atual_d[i] = alvo_q[i];
            end else if (alvo_q[i] > atual_q[i]) begin
               dif        = {1'b0, alvo_q[i]} - {1'b0, atual_q[i]};
               passo_ef   = (dif > PASSO_W) ? PASSO_W : dif;
               atual_d[i] = W_LARG'({1'b0, atual_q[i]} + passo_ef);
            end else if (alvo_q[i] < atual_q[i]) begin
               dif        = {1'b0, atual_q[i]} - {1'b0, alvo_q[i]};
               passo_ef   = (dif > PASSO_W) ? PASSO_W : dif;
               atual_d[i] = W_LARG'({1'b0, atual_q[i]} - passo_ef);
            end
         end
         if (wr_ok && (bus.wr_canal == W_CANAL'(i))) begin
            alvo_d[i] = wr_lim;
         end
      end
   end

   always_comb begin
      bus.movendo = '0;
      for (int i = 0; i < N_CANAIS; i++) begin
         bus.movendo[i] = (atual_q[i] != alvo_q[i]);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         contagem_q <= '0;
         pwm_q      <= '0;
         wr_erro_q  <= 1'b0;
         for (int i = 0; i < N_CANAIS; i++) begin
            alvo_q[i]  <= INIC;
            atual_q[i] <= INIC;
         end
      end else begin
         contagem_q <= contagem_d;
         pwm_q      <= pwm_d;
         wr_erro_q  <= wr_erro_d;
         for (int i = 0; i < N_CANAIS; i++) begin
            alvo_q[i]  <= alvo_d[i];
            atual_q[i] <= atual_d[i];
         end
      end
   end

   assign bus.pwm         = pwm_q;
   assign bus.fim_periodo = fim;
   assign bus.wr_erro     = wr_erro_q;

endmodule

// File: tb/tb_servo_pwm_multicanal.sv
// Bench for servo_pwm_multicanal: two instances (jump and ramp) share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_servo_pwm_multicanal;
   localparam int P    = 20;
   localparam int N    = 3;
   localparam int WL   = 11;
   localparam int WC   = 2;
   localparam int LMAX = 15;

   logic clk = 1'b0;
   logic rst_n;
   logic hab;
   logic wr_en;
   logic [WC-1:0] wr_canal;
   logic [WL-1:0] wr_larg;

   always #5 clk = ~clk;

   servo_pwm_multicanal_if #(.N_CANAIS(N), .W_LARG(WL), .W_CANAL(WC)) if_a ();
   servo_pwm_multicanal_if #(.N_CANAIS(N), .W_LARG(WL), .W_CANAL(WC)) if_b ();

   assign if_a.habilita   = hab;
   assign if_a.wr_en      = wr_en;
   assign if_a.wr_canal   = wr_canal;
   assign if_a.wr_largura = wr_larg;
   assign if_b.habilita   = hab;
   assign if_b.wr_en      = wr_en;
   assign if_b.wr_canal   = wr_canal;
   assign if_b.wr_largura = wr_larg;

   servo_pwm_multicanal #(
      .CONF_PERIODO(P), .N_CANAIS(N), .W_LARG(WL), .W_CANAL(WC),
      .LARGURA_MAX(LMAX), .LARGURA_INICIAL(4), .PASSO(0)
   ) dut_a (.clock_i(clk), .reset_ni(rst_n), .bus(if_a));

   servo_pwm_multicanal #(
      .CONF_PERIODO(P), .N_CANAIS(N), .W_LARG(WL), .W_CANAL(WC),
      .LARGURA_MAX(LMAX), .LARGURA_INICIAL(0), .PASSO(3)
   ) dut_b (.clock_i(clk), .reset_ni(rst_n), .bus(if_b));

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(string nome, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nome, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model (index 0 = jump, 1 = ramp) ----------------
   int m_cnt [2];
   int m_alvo [2][N];
   int m_atual [2][N];
   logic [N-1:0] m_pwm [2];
   logic m_err [2];
   bit m_fim;

   function automatic int passo_of(int m);
      return (m == 0) ? 0 : 3;
   endfunction

   function automatic int inic_of(int m);
      return (m == 0) ? 4 : 0;
   endfunction

   function automatic int min2(int a, int b);
      return (a < b) ? a : b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0;
            m_pwm[m] = '0;
            m_err[m] = 1'b0;
            for (int i = 0; i < N; i++) begin
               m_alvo[m][i]  = inic_of(m);
               m_atual[m][i] = inic_of(m);
            end
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            m_fim = hab && (m_cnt[m] == P - 1);
            for (int i = 0; i < N; i++) m_pwm[m][i] = hab && (m_cnt[m] < m_atual[m][i]);
            m_err[m] = wr_en && (int'(wr_canal) >= N);
            if (m_fim) begin
               for (int i = 0; i < N; i++) begin
                  if (passo_of(m) == 0)
                     m_atual[m][i] = m_alvo[m][i];
                  else if (m_alvo[m][i] > m_atual[m][i])
                     m_atual[m][i] += min2(passo_of(m), m_alvo[m][i] - m_atual[m][i]);
                  else if (m_alvo[m][i] < m_atual[m][i])
                     m_atual[m][i] -= min2(passo_of(m), m_atual[m][i] - m_alvo[m][i]);
               end
            end
            if (wr_en && (int'(wr_canal) < N))
               m_alvo[m][wr_canal] = min2(int'(wr_larg), LMAX);
            m_cnt[m] = (!hab || m_fim) ? 0 : m_cnt[m] + 1;
         end
      end
   end

   function automatic int mov_exp(int m);
      int r = 0;
      for (int i = 0; i < N; i++) if (m_atual[m][i] != m_alvo[m][i]) r |= (1 << i);
      return r;
   endfunction

   always @(negedge clk) begin
      chk("pwm_a", int'(if_a.pwm), int'(m_pwm[0]));
      chk("pwm_b", int'(if_b.pwm), int'(m_pwm[1]));
      chk("movendo_a", int'(if_a.movendo), mov_exp(0));
      chk("movendo_b", int'(if_b.movendo), mov_exp(1));
      chk("fim_a", int'(if_a.fim_periodo), int'(hab && (m_cnt[0] == P - 1)));
      chk("fim_b", int'(if_b.fim_periodo), int'(hab && (m_cnt[1] == P - 1)));
      chk("wr_erro_a", int'(if_a.wr_erro), int'(m_err[0]));
      chk("wr_erro_b", int'(if_b.wr_erro), int'(m_err[1]));
   end

   // ---------------- pulse-width monitor: high cycles per period ----------------
   int acc_a [N];
   int acc_b [N];
   int last_a [N];
   int last_b [N];
   int nper = 0;
   bit prev_fim = 1'b0;

   always @(negedge clk) begin
      if (!rst_n || !hab) begin
         for (int i = 0; i < N; i++) begin
            acc_a[i] = 0;
            acc_b[i] = 0;
         end
         prev_fim = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            acc_a[i] += int'(if_a.pwm[i]);
            acc_b[i] += int'(if_b.pwm[i]);
         end
         if (prev_fim) begin
            for (int i = 0; i < N; i++) begin
               last_a[i] = acc_a[i];
               last_b[i] = acc_b[i];
               acc_a[i]  = 0;
               acc_b[i]  = 0;
            end
            nper++;
         end
         prev_fim = if_a.fim_periodo;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic ciclos(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wr(int c, int v);
      wr_en    = 1'b1;
      wr_canal = WC'(c);
      wr_larg  = WL'(v);
      @(negedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_period();
      int s;
      s = nper;
      for (int k = 0; k < 4 * P; k++) begin
         @(negedge clk);
         #1;
         if (nper != s) return;
      end
      chk("timeout_period", 0, 1);
   endtask

   task automatic wait_fim(output int k_out);
      k_out = -1;
      for (int k = 1; k <= 4 * P; k++) begin
         @(negedge clk);
         #1;
         if (if_a.fim_periodo) begin
            k_out = k;
            return;
         end
      end
      chk("timeout_fim", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      hab = 1'b1; wr_en = 1'b0; wr_canal = '0; wr_larg = '0; rst_n = 1'b0;
      ciclos(3);
      rst_n = 1'b1;

      // Reset values with enable high
      wait_period();
      wait_period();
      for (int i = 0; i < N; i++) begin
         chk("t1_larg_a", last_a[i], 4);
         chk("t1_larg_b", last_b[i], 0);
      end
      chk("t1_movendo_a", int'(if_a.movendo), 0);
      wait_fim(k);
      wait_fim(k);
      chk("t1_periodo", k, P);

      // Jump and clamp
      ciclos(3);
      wr(1, 10);
      wr(2, 30);
      wait_period();
      chk("t2_antigo_a1", last_a[1], 4);
      wait_period();
      chk("t2_larg_a0", last_a[0], 4);
      chk("t2_larg_a1", last_a[1], 10);
      chk("t2_clamp_a2", last_a[2], 15);
      chk("t2_rampa_b1", last_b[1], 3);
      chk("t2_rampa_b2", last_b[2], 3);

      // Ramp up 0 -> 10, then down 10 -> 2
      ciclos(2);
      wr(0, 10);
      wait_period();
      wait_period(); chk("t3_sobe_1", last_b[0], 3);
      wait_period(); chk("t3_sobe_2", last_b[0], 6);
      chk("t3_movendo_antes", int'(if_b.movendo[0]), 1);
      wait_period(); chk("t3_sobe_3", last_b[0], 9);
      chk("t3_movendo_fim", int'(if_b.movendo[0]), 0);
      wait_period(); chk("t3_sobe_4", last_b[0], 10);
      wr(0, 2);
      wait_period();
      wait_period(); chk("t3_desce_1", last_b[0], 7);
      wait_period(); chk("t3_desce_2", last_b[0], 4);
      wait_period(); chk("t3_desce_3", last_b[0], 2);
      chk("t3_salto_a0", last_a[0], 2);

      // Write on the boundary cycle uses the old target for one more period
      wait_fim(k);
      wr(0, 8);
      wait_period();
      chk("t4_antigo_a", last_a[0], 2);
      chk("t4_antigo_b", last_b[0], 2);
      wait_period();
      chk("t4_novo_a", last_a[0], 8);
      chk("t4_novo_b", last_b[0], 5);

      // Invalid channel, enable low, re-enable
      ciclos(3);
      wr(3, 5);
      chk("t5_wr_erro_pulso", int'(if_a.wr_erro), 1);
      ciclos(1);
      chk("t5_wr_erro_fim", int'(if_a.wr_erro), 0);
      chk("t5_sem_efeito", int'(if_a.movendo), 0);
      hab = 1'b0;
      ciclos(3);
      wr(2, 5);
      ciclos(3);
      chk("t5_pwm_parado_a", int'(if_a.pwm), 0);
      chk("t5_pwm_parado_b", int'(if_b.pwm), 0);
      chk("t5_alvo_aceito", int'(if_a.movendo[2]), 1);
      hab = 1'b1;
      wait_fim(k);
      chk("t5_fim_reinicio", k, P - 1);
      wait_period();
      chk("t5_reinicio_a0", last_a[0], 8);
      chk("t5_reinicio_a1", last_a[1], 10);
      chk("t5_congelado_a2", last_a[2], 15);
      wait_period();
      chk("t5_atualiza_a2", last_a[2], 5);

      // Randomized traffic
      for (int c = 0; c < 800; c++) begin
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_canal = WC'($urandom_range(0, 3));
         wr_larg  = WL'($urandom_range(0, 40));
         if ($urandom_range(0, 99) == 0) hab = ~hab;
         ciclos(1);
      end
      wr_en = 1'b0;
      hab   = 1'b1;

      // Asynchronous reset in the middle of a period and ramp
      ciclos(1);
      wr(0, 15);
      wr(1, 15);
      wr(2, 15);
      wait_period();
      wait_period();
      @(posedge clk);
      #3;
      chk("t6_pwm_antes", int'(if_a.pwm), 7);
      rst_n = 1'b0;
      #1;
      chk("t6_pwm_reset_a", int'(if_a.pwm), 0);
      chk("t6_pwm_reset_b", int'(if_b.pwm), 0);
      chk("t6_movendo_reset_b", int'(if_b.movendo), 0);
      ciclos(3);
      rst_n = 1'b1;
      wait_period();
      wait_period();
      for (int i = 0; i < N; i++) begin
         chk("t6_larg_a", last_a[i], 4);
         chk("t6_larg_b", last_b[i], 0);
      end
      chk("t6_movendo_a", int'(if_a.movendo), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
